b09_serial_tx: RTL

Serial word transmitter that drives the single-wire X stream consumed by the b09 serial converter. It accepts 8-bit words on a valid/ready parallel port, buffers up to two of them, and shifts each out as a framed serial sequence: start bit, 8 data bits LSB first, then idle gap bits. It sits upstream of b09 in the benchmark test harness and lets the converter be exercised with a controlled, cycle-exact word stream.

---
 rtl/b09_serial_tx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/b09_serial_tx.sv
// Framed serial word transmitter feeding the b09 converter's X input.
// Two-word input FIFO, start bit + 8 data bits LSB first + idle gap bits.
module b09_serial_tx #(
    parameter int BIT_DIV  = 1,
    parameter int GAP_BITS = 1
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [7:0] DATA_IN,
    input  logic       VALID,
    output logic       READY,
    output logic       X,
    output logic       BUSY,
    output logic       WORD_SENT
);

    typedef enum logic [1:0] {IDLE, START, DATA, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(BIT_DIV - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);

    state_t          state_q, state_d;
    logic [7:0]      div_q, div_d;
    logic [3:0]      idx_q, idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [1:0][7:0] mem_q, mem_d;
    logic [1:0]      count_q, count_d;
    logic            x_q, x_d;
    logic            busy_q, busy_d;
    logic            ws_q, ws_d;
    logic            ready_q, ready_d;
    logic            bit_end, pop, push;
    logic [1:0]      wr_idx;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        ws_d    = 1'b0;
        bit_end = (div_q == DIV_LAST);

        case (state_q)
            IDLE: begin
                if (count_q != 2'd0) begin
                    pop     = 1'b1;
                    state_d = START;
                    div_d   = 8'd0;
                    idx_d   = 4'd0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    div_d   = 8'd0;
                    idx_d   = 4'd0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    div_d   = 8'd0;
                    shreg_d = shreg_q >> 1;
                    if (idx_q == 4'd7) begin
                        state_d = GAP;
                        idx_d   = 4'd0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            GAP: begin
                if (bit_end) begin
                    div_d = 8'd0;
                    if (idx_q == GAP_LAST) begin
                        // Chain straight into the next frame when a word is waiting.
                        ws_d  = 1'b1;
                        idx_d = 4'd0;
                        if (count_q != 2'd0) begin
                            pop     = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) shreg_d = mem_q[0];
    end

    // FIFO: head is entry 0; a push lands behind whatever survives the pop.
    always_comb begin
        push    = VALID && ready_q;
        mem_d   = mem_q;
        wr_idx  = count_q - 2'(pop);
        if (pop) mem_d[0] = mem_q[1];
        if (push) mem_d[wr_idx[0]] = DATA_IN;
        count_d = count_q + 2'(push) - 2'(pop);
        ready_d = (count_d != 2'd2);
    end

    always_comb begin
        x_d    = 1'b0;
        busy_d = (state_q != IDLE);
        case (state_q)
            START:   x_d = 1'b1;
            DATA:    x_d = shreg_q[0];
            default: x_d = 1'b0;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q <= IDLE;
            div_q   <= 8'd0;
            idx_q   <= 4'd0;
            shreg_q <= 8'd0;
            mem_q   <= '0;
            count_q <= 2'd0;
            x_q     <= 1'b0;
            busy_q  <= 1'b0;
            ws_q    <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            mem_q   <= mem_d;
            count_q <= count_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            ws_q    <= ws_d;
            ready_q <= ready_d;
        end
    end

    assign READY     = ready_q;
    assign X         = x_q;
    assign BUSY      = busy_q;
    assign WORD_SENT = ws_q;

endmodule
